// File: rtl/mem_stage_ctrl_if.sv
// Handshake and data bundle between the pipeline neighbours (EX, WB, ID, data SRAM) and the MEM stage.
interface mem_stage_ctrl_if #(
    parameter int unsigned TO_MEM_W = 71,
    parameter int unsigned TO_WB_W  = 70
);
    logic                EX_to_MEM_valid;
    logic [TO_MEM_W-1:0] to_MEM_data;
    logic                MEM_allow_in;
    logic                WB_allow_in;
    logic                MEM_to_WB_valid;
    logic [TO_WB_W-1:0]  to_WB_data;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;
    logic [37:0]         MEM_fwd;
    logic                MEM_load_busy;
    logic                mem_timeout;

    // Pipeline environment side: EX, WB, data SRAM and ID.
    modport master (
        output EX_to_MEM_valid, to_MEM_data, WB_allow_in, data_sram_data_ok, data_sram_rdata,
        input  MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_fwd, MEM_load_busy, mem_timeout
    );

    // MEM stage side.
    modport slave (
        input  EX_to_MEM_valid, to_MEM_data, WB_allow_in, data_sram_data_ok, data_sram_rdata,
        output MEM_allow_in, MEM_to_WB_valid, to_WB_data, MEM_fwd, MEM_load_busy, mem_timeout
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: latches the EX bundle, waits for variable-latency load data, hands the
// final result to WB and exports bypass / load-use information to ID.
module mem_stage_ctrl #(
    parameter int unsigned TO_MEM_W = 71,
    parameter int unsigned TO_WB_W  = 70,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_pc;
    logic [31:0]        r_alu;
    logic               r_rfm;
    logic [4:0]         r_dest;
    logic               r_we;
    logic [31:0]        r_hold;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_timeout;

    logic [TO_MEM_W-1:0] w_in;
    logic [31:0]        w_in_pc;
    logic [31:0]        w_in_alu;
    logic               w_in_rfm;
    logic [4:0]         w_in_dest;
    logic               w_in_we;

    logic               w_ready_go;
    logic               w_allow_in;
    logic               w_accept;
    logic               w_leave;
    logic               w_capture;
    logic               w_load_busy;
    logic               w_wait_stall;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        w_final;
    logic               w_fwd_we;

    assign w_in      = bus.to_MEM_data;
    assign w_in_pc   = w_in[TO_MEM_W-1  -: 32];
    assign w_in_alu  = w_in[TO_MEM_W-33 -: 32];
    assign w_in_rfm  = w_in[6];
    assign w_in_dest = w_in[5:1];
    assign w_in_we   = w_in[0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake decode and next-state logic; an accept in the leaving cycle overrides the return to IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready_go   = 1'b0;
        w_allow_in   = 1'b0;
        w_accept     = 1'b0;
        w_leave      = 1'b0;
        w_capture    = 1'b0;
        w_load_busy  = 1'b0;
        w_wait_stall = 1'b0;

        w_ready_go   = (r_state == S_DONE) | ((r_state == S_WAIT) & bus.data_sram_data_ok);
        w_leave      = w_ready_go & bus.WB_allow_in;
        w_allow_in   = (r_state == S_IDLE) | w_leave;
        w_accept     = bus.EX_to_MEM_valid & w_allow_in;
        w_load_busy  = (r_state == S_WAIT) & ~bus.data_sram_data_ok;
        w_wait_stall = w_load_busy;
        w_capture    = (r_state == S_WAIT) & bus.data_sram_data_ok & ~bus.WB_allow_in;

        if (w_accept) begin
            w_state_nxt = w_in_rfm ? S_WAIT : S_DONE;
        end else if (w_leave) begin
            w_state_nxt = S_IDLE;
        end else if (w_capture) begin
            w_state_nxt = S_DONE;
        end
    end

    assign w_cnt_nxt = (r_wait_cnt == {CNT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    // Bundle, load-data hold register, wait counter and sticky timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= 32'd0;
            r_alu      <= 32'd0;
            r_rfm      <= 1'b0;
            r_dest     <= 5'd0;
            r_we       <= 1'b0;
            r_hold     <= 32'd0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pc   <= w_in_pc;
                r_alu  <= w_in_alu;
                r_rfm  <= w_in_rfm;
                r_dest <= w_in_dest;
                r_we   <= w_in_we;
            end
            if (w_capture) begin
                r_hold <= bus.data_sram_rdata;
            end
            if (w_accept && w_in_rfm) begin
                r_wait_cnt <= '0;
            end else if (w_wait_stall) begin
                r_wait_cnt <= w_cnt_nxt;
                if (w_cnt_nxt == CNT_W'(WAIT_MAX)) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    // Result mux: live SRAM data in WAIT, captured copy once parked in DONE.
    always_comb begin
        w_final = r_alu;
        if (r_rfm) begin
            w_final = (r_state == S_WAIT) ? bus.data_sram_rdata : r_hold;
        end
    end

    assign w_fwd_we = r_we & (r_state != S_IDLE) & ~w_load_busy;

    assign bus.MEM_allow_in    = w_allow_in;
    assign bus.MEM_to_WB_valid = w_ready_go;
    assign bus.to_WB_data      = w_ready_go ? TO_WB_W'({r_pc, w_final, r_dest, r_we}) : '0;
    assign bus.MEM_fwd         = (r_state == S_IDLE) ? 38'd0 : {w_fwd_we, r_dest, w_final};
    assign bus.MEM_load_busy   = w_load_busy;
    assign bus.mem_timeout     = r_timeout;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected WB bundles are queued at issue and checked by a
// separate monitor on every WB transfer; control outputs are checked inline.
module tb_mem_stage_ctrl;
    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    logic [69:0] exp_q[$];

    mem_stage_ctrl_if #(.TO_MEM_W(71), .TO_WB_W(70)) bus ();

    mem_stage_ctrl #(.TO_MEM_W(71), .TO_WB_W(70), .WAIT_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle until MEM accepts it; optionally queue the WB bundle it must produce.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic rfm,
                         input logic [4:0] dest, input logic we, input logic [31:0] res,
                         input bit push);
        logic acc;
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = {pc, alu, rfm, dest, we};
        if (push) exp_q.push_back({pc, res, dest, we});
        for (int i = 0; i < 50; i++) begin
            #1;
            acc = bus.MEM_allow_in;
            step();
            if (acc) begin
                bus.EX_to_MEM_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL issue_accept: bundle pc=%h not accepted within 50 cycles", pc);
        bus.EX_to_MEM_valid = 1'b0;
    endtask

    // Monitor: every WB transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.MEM_to_WB_valid && bus.WB_allow_in) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: got %h expected no transfer", bus.to_WB_data);
            end else begin
                chk("wb_data", bus.to_WB_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs[4];
        logic [31:0] alus[4];

        reset                 = 1'b1;
        bus.EX_to_MEM_valid   = 1'b0;
        bus.to_MEM_data       = '0;
        bus.WB_allow_in       = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'd0;
        step();
        step();

        // Reset state
        #1;
        chk("rst_valid",   70'(bus.MEM_to_WB_valid), 70'd0);
        chk("rst_allow",   70'(bus.MEM_allow_in),    70'd1);
        chk("rst_fwd",     70'(bus.MEM_fwd),         70'd0);
        chk("rst_busy",    70'(bus.MEM_load_busy),   70'd0);
        chk("rst_timeout", 70'(bus.mem_timeout),     70'd0);
        chk("rst_wbdata",  bus.to_WB_data,           70'd0);
        step();
        reset = 1'b0;

        // Stale data_ok in IDLE is ignored
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h55aa55aa;
        #1;
        chk("stale_valid", 70'(bus.MEM_to_WB_valid), 70'd0);
        step();
        bus.data_sram_data_ok = 1'b0;
        #1;
        chk("stale_allow", 70'(bus.MEM_allow_in), 70'd1);
        chk("stale_fwd",   70'(bus.MEM_fwd),      70'd0);
        step();

        // 1: single ALU op
        bus.WB_allow_in = 1'b1;
        issue(32'h1c000000, 32'h00001234, 1'b0, 5'd5, 1'b1, 32'h00001234, 1'b1);
        #1;
        chk("alu_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        chk("alu_fwd",   70'(bus.MEM_fwd), 70'({1'b1, 5'd5, 32'h00001234}));
        step();
        #1;
        chk("alu_idle_valid", 70'(bus.MEM_to_WB_valid), 70'd0);
        chk("alu_idle_fwd",   70'(bus.MEM_fwd), 70'd0);
        step();

        // 2: load with data_ok after 3 busy cycles
        issue(32'h1c000004, 32'h00000100, 1'b1, 5'd7, 1'b1, 32'hdeadbeef, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ld_busy",   70'(bus.MEM_load_busy),   70'd1);
            chk("ld_allow",  70'(bus.MEM_allow_in),    70'd0);
            chk("ld_valid0", 70'(bus.MEM_to_WB_valid), 70'd0);
            chk("ld_fwd_we", 70'(bus.MEM_fwd[37]),     70'd0);
            step();
        end
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hdeadbeef;
        #1;
        chk("ld_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        chk("ld_nobusy", 70'(bus.MEM_load_busy),  70'd0);
        chk("ld_fwd",   70'(bus.MEM_fwd), 70'({1'b1, 5'd7, 32'hdeadbeef}));
        chk("ld_allow1", 70'(bus.MEM_allow_in),   70'd1);
        step();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'd0;
        #1;
        chk("ld_done_valid", 70'(bus.MEM_to_WB_valid), 70'd0);
        chk("ld_timeout",    70'(bus.mem_timeout),     70'd0);
        step();

        // 3: load data arrives while WB stalls; held in DONE and sent once
        bus.WB_allow_in = 1'b0;
        issue(32'h1c000008, 32'h00000200, 1'b1, 5'd9, 1'b1, 32'hcafef00d, 1'b1);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hcafef00d;
        #1;
        chk("hold_valid0", 70'(bus.MEM_to_WB_valid), 70'd1);
        chk("hold_allow0", 70'(bus.MEM_allow_in),    70'd0);
        step();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("hold_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
            chk("hold_fwd",   70'(bus.MEM_fwd), 70'({1'b1, 5'd9, 32'hcafef00d}));
            chk("hold_allow", 70'(bus.MEM_allow_in), 70'd0);
            step();
        end
        bus.WB_allow_in = 1'b1;
        #1;
        chk("hold_release_allow", 70'(bus.MEM_allow_in), 70'd1);
        step();
        #1;
        chk("hold_gone", 70'(bus.MEM_to_WB_valid), 70'd0);
        step();

        // 4: back-to-back ALU bundles, then one WB stall
        pcs  = '{32'h1c000010, 32'h1c000014, 32'h1c000018, 32'h1c00001c};
        alus = '{32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044};
        for (int i = 0; i < 4; i++) begin
            bus.EX_to_MEM_valid = 1'b1;
            bus.to_MEM_data     = {pcs[i], alus[i], 1'b0, 5'(i + 1), 1'b1};
            exp_q.push_back({pcs[i], alus[i], 5'(i + 1), 1'b1});
            #1;
            chk("b2b_allow", 70'(bus.MEM_allow_in), 70'd1);
            if (i > 0) chk("b2b_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
            step();
        end
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        chk("b2b_last_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        step();
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = {32'h1c000020, 32'h000000e0, 1'b0, 5'd14, 1'b1};
        exp_q.push_back({32'h1c000020, 32'h000000e0, 5'd14, 1'b1});
        #1;
        chk("stall_allow_e", 70'(bus.MEM_allow_in), 70'd1);
        step();
        bus.to_MEM_data = {32'h1c000024, 32'h000000f0, 1'b0, 5'd15, 1'b0};
        exp_q.push_back({32'h1c000024, 32'h000000f0, 5'd15, 1'b0});
        bus.WB_allow_in = 1'b0;
        #1;
        chk("stall_allow0", 70'(bus.MEM_allow_in),    70'd0);
        chk("stall_valid",  70'(bus.MEM_to_WB_valid), 70'd1);
        step();
        bus.WB_allow_in = 1'b1;
        #1;
        chk("stall_allow1", 70'(bus.MEM_allow_in), 70'd1);
        step();
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        chk("stall_f_valid", 70'(bus.MEM_to_WB_valid), 70'd1);
        chk("stall_f_fwd",   70'(bus.MEM_fwd), 70'({1'b0, 5'd15, 32'h000000f0}));
        step();
        #1;
        chk("stall_end_valid", 70'(bus.MEM_to_WB_valid), 70'd0);
        step();

        // 5: reset during WAIT drops the load; the late data_ok is ignored
        issue(32'h1c000030, 32'h00000300, 1'b1, 5'd11, 1'b1, 32'h0, 1'b0);
        #1;
        chk("rw_busy", 70'(bus.MEM_load_busy), 70'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h11111111;
        #1;
        chk("rw_valid",   70'(bus.MEM_to_WB_valid), 70'd0);
        chk("rw_allow",   70'(bus.MEM_allow_in),    70'd1);
        chk("rw_timeout", 70'(bus.mem_timeout),     70'd0);
        chk("rw_busy0",   70'(bus.MEM_load_busy),   70'd0);
        chk("rw_fwd",     70'(bus.MEM_fwd),         70'd0);
        step();
        bus.data_sram_data_ok = 1'b0;
        #1;
        chk("rw_valid2", 70'(bus.MEM_to_WB_valid), 70'd0);
        step();

        // 6: timeout after 4 WAIT cycles, sticky, load still completes
        issue(32'h1c000040, 32'h00000400, 1'b1, 5'd3, 1'b1, 32'h600df00d, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("to_flag", 70'(bus.mem_timeout), (c >= 5) ? 70'd1 : 70'd0);
            chk("to_busy", 70'(bus.MEM_load_busy), 70'd1);
            step();
        end
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h600df00d;
        #1;
        chk("to_valid",  70'(bus.MEM_to_WB_valid), 70'd1);
        chk("to_flag_ok", 70'(bus.mem_timeout),    70'd1);
        step();
        bus.data_sram_data_ok = 1'b0;
        #1;
        chk("to_sticky", 70'(bus.mem_timeout),     70'd1);
        chk("to_idle",   70'(bus.MEM_to_WB_valid), 70'd0);
        step();

        repeat (3) step();
        chk("queue_drained", 70'(exp_q.size()), 70'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
